// File: rtl/edge_threshold_stats_pkg.sv
// edge_pkg: shared widths, direction bins and edge pixel codes for the
// edge thresholding / statistics stage and its direction quantiser.
package edge_pkg;

  localparam int GRAD_W = 9;   // signed gradient component width
  localparam int MOD_W  = 17;  // unsigned squared modulus width
  localparam int PROD_W = 11;  // holds 5*255 without overflow

  typedef enum logic [1:0] {
    DIR_H    = 2'd0,
    DIR_D45  = 2'd1,
    DIR_V    = 2'd2,
    DIR_D135 = 2'd3
  } dir_e;

  localparam logic [7:0] EDGE_ON  = 8'hFF;
  localparam logic [7:0] EDGE_OFF = 8'h00;

  // Magnitude of a two's-complement gradient; inputs are limited to
  // -255..255 so the result always fits the same width.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? (~g + GRAD_W'(1)) : g;
  endfunction

endpackage

// File: rtl/edge_threshold_stats_if.sv
// edge_threshold_stats_if: pixel stream bus of the edge stage.
//  Upstream side : de_in, hsync_in, vsync_in, gradient_x_in, gradient_y_in,
//                  squared_modulus_in (driven by master)
//  Downstream side: de_out, hsync_out, vsync_out, edge_pixel_out,
//                  edge_dir_out (driven by slave, i.e. the edge stage)
interface edge_threshold_stats_if;
  import edge_pkg::*;

  logic              de_in;
  logic              hsync_in;
  logic              vsync_in;
  logic [GRAD_W-1:0] gradient_x_in;
  logic [GRAD_W-1:0] gradient_y_in;
  logic [MOD_W-1:0]  squared_modulus_in;

  logic              de_out;
  logic              hsync_out;
  logic              vsync_out;
  logic [7:0]        edge_pixel_out;
  logic [1:0]        edge_dir_out;

  modport master (
    output de_in, hsync_in, vsync_in, gradient_x_in, gradient_y_in, squared_modulus_in,
    input  de_out, hsync_out, vsync_out, edge_pixel_out, edge_dir_out
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, gradient_x_in, gradient_y_in, squared_modulus_in,
    output de_out, hsync_out, vsync_out, edge_pixel_out, edge_dir_out
  );

endinterface

// File: rtl/edge_threshold_stats_dir_quantizer.sv
// gradient_dir_quantizer: combinational 4-bin direction classifier.
//  ax, ay in : gradient magnitudes (unsigned)
//  sgn    in : Gx sign xor Gy sign (1 = 135 deg diagonal)
//  dir    out: direction bin
// tan(22.5) ~ 0.4 is approximated by comparing 5*a against 2*b with
// shift-add products only.
module gradient_dir_quantizer
  import edge_pkg::*;
(
  input  logic [GRAD_W-1:0] ax,
  input  logic [GRAD_W-1:0] ay,
  input  logic              sgn,
  output dir_e              dir
);

  logic [PROD_W-1:0] ax_ext, ay_ext;
  logic [PROD_W-1:0] ax5, ay5, ax2, ay2;

  assign ax_ext = {{(PROD_W-GRAD_W){1'b0}}, ax};
  assign ay_ext = {{(PROD_W-GRAD_W){1'b0}}, ay};
  assign ax5    = (ax_ext << 2) + ax_ext;
  assign ay5    = (ay_ext << 2) + ay_ext;
  assign ax2    = ax_ext << 1;
  assign ay2    = ay_ext << 1;

  always_comb begin
    dir = DIR_H;
    if (ay5 < ax2)      dir = DIR_H;
    else if (ax5 < ay2) dir = DIR_V;
    else if (!sgn)      dir = DIR_D45;
    else                dir = DIR_D135;
  end

endmodule

// File: rtl/edge_threshold_stats.sv
// edge_threshold_stats: thresholds the squared gradient modulus, bins the
// gradient direction and emits a binary edge stream (2-cycle latency, syncs
// kept aligned). Counts edges per direction and latches the counts at every
// frame boundary.
//  pclk, reset_n   : pixel clock, asynchronous active-low reset
//  pix             : pixel stream bus (slave side)
//  threshold_sq_in : requested threshold, taken on vsync_in rising edge
//  hist_out        : previous frame counts, bin k at [k*CNT_W +: CNT_W]
//  frame_done_out  : one-cycle pulse when hist_out updates
module edge_threshold_stats
  import edge_pkg::*;
#(
  parameter logic [MOD_W-1:0] THRESH_DEFAULT = 17'd4096,
  parameter int               CNT_W          = 20
) (
  input  logic                  pclk,
  input  logic                  reset_n,
  edge_threshold_stats_if.slave pix,
  input  logic [MOD_W-1:0]      threshold_sq_in,
  output logic [4*CNT_W-1:0]    hist_out,
  output logic                  frame_done_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Threshold shadow: only swapped at the input-side frame boundary.
  logic [MOD_W-1:0] active_thr_reg;
  logic             vsync_prev_reg;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      active_thr_reg <= THRESH_DEFAULT;
      vsync_prev_reg <= 1'b0;
    end else begin
      vsync_prev_reg <= pix.vsync_in;
      if (pix.vsync_in && !vsync_prev_reg)
        active_thr_reg <= threshold_sq_in;
    end
  end

  // Stage 1: magnitudes, sign and threshold hit.
  logic              s1_de_reg, s1_hs_reg, s1_vs_reg, s1_hit_reg, s1_sgn_reg;
  logic [GRAD_W-1:0] s1_ax_reg, s1_ay_reg;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de_reg  <= 1'b0;
      s1_hs_reg  <= 1'b0;
      s1_vs_reg  <= 1'b0;
      s1_hit_reg <= 1'b0;
      s1_sgn_reg <= 1'b0;
      s1_ax_reg  <= '0;
      s1_ay_reg  <= '0;
    end else begin
      s1_de_reg  <= pix.de_in;
      s1_hs_reg  <= pix.hsync_in;
      s1_vs_reg  <= pix.vsync_in;
      s1_hit_reg <= pix.de_in && (pix.squared_modulus_in >= active_thr_reg);
      s1_sgn_reg <= pix.gradient_x_in[GRAD_W-1] ^ pix.gradient_y_in[GRAD_W-1];
      s1_ax_reg  <= abs_grad(pix.gradient_x_in);
      s1_ay_reg  <= abs_grad(pix.gradient_y_in);
    end
  end

  dir_e s1_dir;

  gradient_dir_quantizer u_quant (
    .ax  (s1_ax_reg),
    .ay  (s1_ay_reg),
    .sgn (s1_sgn_reg),
    .dir (s1_dir)
  );

  // Stage 2: registered outputs.
  logic       s2_de_reg, s2_hs_reg, s2_vs_reg, s2_done_reg;
  logic [7:0] s2_pix_reg;
  logic [1:0] s2_dir_reg;
  logic       frame_end;

  // Frame end is the rising edge of the delayed vsync, so the counters close
  // exactly on the pixels that have left the pipeline.
  assign frame_end = s1_vs_reg && !s2_vs_reg;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s2_de_reg   <= 1'b0;
      s2_hs_reg   <= 1'b0;
      s2_vs_reg   <= 1'b0;
      s2_done_reg <= 1'b0;
      s2_pix_reg  <= EDGE_OFF;
      s2_dir_reg  <= 2'd0;
    end else begin
      s2_de_reg   <= s1_de_reg;
      s2_hs_reg   <= s1_hs_reg;
      s2_vs_reg   <= s1_vs_reg;
      s2_done_reg <= frame_end;
      s2_pix_reg  <= s1_hit_reg ? EDGE_ON : EDGE_OFF;
      s2_dir_reg  <= s1_hit_reg ? s1_dir : DIR_H;
    end
  end

  assign pix.de_out         = s2_de_reg;
  assign pix.hsync_out      = s2_hs_reg;
  assign pix.vsync_out      = s2_vs_reg;
  assign pix.edge_pixel_out = s2_pix_reg;
  assign pix.edge_dir_out   = s2_dir_reg;
  assign frame_done_out     = s2_done_reg;

  // Per-direction saturating counters and histogram latch. The latch takes
  // the incremented value so an edge on the closing cycle is not lost.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bin
    logic [CNT_W-1:0] cnt_reg, cnt_next, hist_reg;

    always_comb begin
      cnt_next = cnt_reg;
      if (s1_hit_reg && (s1_dir == dir_e'(gi)) && (cnt_reg != CNT_MAX))
        cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg  <= '0;
        hist_reg <= '0;
      end else if (frame_end) begin
        cnt_reg  <= '0;
        hist_reg <= cnt_next;
      end else begin
        cnt_reg  <= cnt_next;
      end
    end

    assign hist_out[gi*CNT_W +: CNT_W] = hist_reg;
  end

endmodule
